// File: rtl/align_pkg.sv
// Constants and tx state type shared by both ends of the 16-bit aligned-frame link.
package align_pkg;
  localparam int          ALIGN_DATA_W    = 16;
  localparam int          ALIGN_FRAME_LEN = 18;
  localparam logic [15:0] ALIGN_SYNC_WORD = 16'hAAAA;
  localparam logic [15:0] ALIGN_IDLE_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    PAY  = 2'd2,
    GAP  = 2'd3
  } tx_state_t;
endpackage

// File: rtl/align_frame_tx.sv
// Frame RAM -> link serialiser: SYNC_WORD then FRAME_LEN payload words, MIN_GAP idle words between frames.
// Start-to-SYNC latency 2 clk, no backpressure; one start request may queue while a frame is in flight.
module align_frame_tx
  import align_pkg::*;
#(
  parameter int                DATA_W    = ALIGN_DATA_W,
  parameter int                ADDR_W    = 5,
  parameter int                FRAME_LEN = ALIGN_FRAME_LEN,
  parameter logic [DATA_W-1:0] SYNC_WORD = ALIGN_SYNC_WORD,
  parameter logic [DATA_W-1:0] IDLE_WORD = ALIGN_IDLE_WORD,
  parameter int                MIN_GAP   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt
);

  localparam int                GCNT_W   = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam logic [GCNT_W-1:0] LAST_GAP = GCNT_W'(MIN_GAP - 1);

  tx_state_t         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      gcnt_q      <= '0;
      pending_q   <= 1'b0;
      raddr_q     <= '0;
      out_q       <= IDLE_WORD;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gcnt_q      <= gcnt_d;
      pending_q   <= pending_d;
      raddr_q     <= raddr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gcnt_d      = gcnt_q;
    raddr_d     = raddr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    // A start seen in any non-idle state, including the last gap cycle, is held for the next frame.
    pending_d   = pending_q | (start && (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          raddr_d = '0;
          busy_d  = 1'b1;
          state_d = SYNC;
        end
      end
      SYNC: begin
        out_d       = SYNC_WORD;
        out_valid_d = 1'b1;
        raddr_d     = ADDR_W'(1);
        idx_d       = '0;
        state_d     = PAY;
      end
      PAY: begin
        out_d       = rdata;
        out_valid_d = 1'b1;
        // Prefetch two ahead to cover the RAM's one-cycle read latency; hold at the last word.
        if (({1'b0, idx_q} + (ADDR_W+1)'(2)) <= {1'b0, LAST_IDX})
          raddr_d = idx_q + ADDR_W'(2);
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          gcnt_d  = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        out_d       = IDLE_WORD;
        out_valid_d = 1'b0;
        if (gcnt_q == '0) begin
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
        if (gcnt_q == LAST_GAP) begin
          if (pending_d) begin
            raddr_d   = '0;
            pending_d = 1'b0;
            state_d   = SYNC;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          gcnt_d = gcnt_q + GCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign raddr     = raddr_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_align_frame_tx.sv
// Bench for align_frame_tx: 32x16 sync RAM model, expected-word queue and a simple rx aligner model.
module tb_align_frame_tx;
  import align_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] rdata;
  logic [4:0]  raddr;
  logic [15:0] out;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  logic [15:0] mem [32];
  always @(posedge clk) rdata <= mem[raddr];

  align_frame_tx dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rdata     (rdata),
    .raddr     (raddr),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q [$];
  logic [15:0] sb_exp;
  bit          sb_en = 1'b1;
  int          done_cnt = 0;
  int          max_raddr = 0;
  bit          armed = 1'b0;
  logic [4:0]  rx_n = 5'd0;
  int          rx_frames = 0;
  logic [15:0] rx_buf [18];

  // Output monitor: scoreboard pop on valid words, idle fill check, rx aligner model.
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(raddr) > max_raddr) max_raddr = int'(raddr);
      if (int'(raddr) > 17) begin
        errors++;
        $display("FAIL raddr_range: got %0d, required <= 17", raddr);
      end
      if (done) done_cnt++;
      if (out_valid) begin
        if (sb_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got %h, required no valid word", out);
          end else begin
            sb_exp = exp_q.pop_front();
            if (out !== sb_exp) begin
              errors++;
              $display("FAIL sb_word: got %h, required %h", out, sb_exp);
            end
          end
        end
        if (!armed) begin
          if (out == 16'hAAAA) begin
            armed = 1'b1;
            rx_n  = 5'd0;
          end
        end else begin
          rx_buf[rx_n] = out;
          if (rx_n == 5'd17) begin
            armed = 1'b0;
            rx_frames++;
          end
          rx_n = rx_n + 5'd1;
        end
      end else begin
        checks++;
        if (out !== 16'h0000) begin
          errors++;
          $display("FAIL idle_fill: got %h, required 0000", out);
        end
      end
    end else begin
      armed = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    exp_q.push_back(16'hAAAA);
    for (int i = 0; i < 18; i++) exp_q.push_back(mem[i]);
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL rst_out: got %h, required 0000", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d, required 0", frame_cnt); end
    checks++; if (raddr !== 5'd0) begin errors++; $display("FAIL rst_raddr: got %0d, required 0", raddr); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    apply_reset();
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (out !== 16'h0000 || out_valid !== 1'b0) begin errors++; $display("FAIL t1_accept_cycle: got %h/%b, required 0000/0", out, out_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy_set: got %b, required 1", busy); end
    tick();
    checks++; if (out !== 16'hAAAA || out_valid !== 1'b1) begin errors++; $display("FAIL t1_sync: got %h/%b, required aaaa/1", out, out_valid); end
    for (int k = 0; k < 18; k++) begin
      tick();
      checks++;
      if (out !== 16'h0100 + 16'(k) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL t1_payload_%0d: got %h/%b, required %h/1", k, out, out_valid, 16'h0100 + 16'(k));
      end
    end
    tick();
    checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL t1_done: got done=%b valid=%b, required 1/0", done, out_valid); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL t1_frame_cnt: got %0d, required 1", frame_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy_gap: got %b, required 1", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse: got %b, required 0", done); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_clear: got %b, required 0", busy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t1_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit found;
    int gap;
    apply_reset();
    push_frame();
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (out_valid && out == 16'h0103) begin
        found = 1'b1;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    checks++; if (!found) begin errors++; $display("FAIL t2_word3_timeout: got no word 0103, required one"); end
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (out_valid && out == 16'h0111) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL t2_last_timeout: got no word 0111, required one"); end
    gap = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) break;
      gap++;
    end
    checks++; if (gap != 2) begin errors++; $display("FAIL t2_gap: got %0d idle cycles, required 2", gap); end
    checks++; if (out !== 16'hAAAA) begin errors++; $display("FAIL t2_second_sync: got %h, required aaaa", out); end
    wait_idle("t2", 60);
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL t2_frame_cnt: got %0d, required 2", frame_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t2_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_extra_starts();
    int d0;
    apply_reset();
    d0 = done_cnt;
    push_frame();
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      start = out_valid && (frame_cnt == 8'd0) &&
              (out == 16'h0102 || out == 16'h0105 || out == 16'h0109);
      tick();
    end
    start = 1'b0;
    wait_idle("t3", 60);
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL t3_frame_cnt: got %0d, required 2", frame_cnt); end
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL t3_done_pulses: got %0d, required 2", done_cnt - d0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t3_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    int d0;
    apply_reset();
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (out_valid && out == 16'h010A) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL t4_word10_timeout: got no word 010a, required one"); end
    d0  = done_cnt;
    rst = 1'b1;
    tick();
    exp_q.delete();
    checks++; if (out !== 16'h0000 || out_valid !== 1'b0) begin errors++; $display("FAIL t4_out: got %h/%b, required 0000/0", out, out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t4_done: got %b, required 0", done); end
    rst = 1'b0;
    repeat (30) tick();
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL t4_no_done: got %0d pulses, required 0", done_cnt - d0); end
    checks++; if (frame_cnt !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL t4_quiet: got cnt=%0d busy=%b, required 0/0", frame_cnt, busy); end
  endtask

  task automatic test_sync_in_payload();
    int r0;
    mem[4] = 16'hAAAA;
    apply_reset();
    r0 = rx_frames;
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("t5", 60);
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL t5_frame_cnt: got %0d, required 1", frame_cnt); end
    checks++; if (rx_frames - r0 != 1) begin errors++; $display("FAIL t5_rx_frames: got %0d, required 1", rx_frames - r0); end
    checks++; if (rx_buf[0] !== 16'h0100) begin errors++; $display("FAIL t5_rx_word0: got %h, required 0100", rx_buf[0]); end
    checks++; if (rx_buf[4] !== 16'hAAAA) begin errors++; $display("FAIL t5_rx_word4: got %h, required aaaa", rx_buf[4]); end
    checks++; if (rx_buf[17] !== 16'h0111) begin errors++; $display("FAIL t5_rx_word17: got %h, required 0111", rx_buf[17]); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t5_sb_drain: got %0d left, required 0", exp_q.size()); end
    mem[4] = 16'h0104;
  endtask

  task automatic test_wrap();
    int n;
    int bad;
    sb_en = 1'b0;
    apply_reset();
    n   = 0;
    bad = 0;
    start = 1'b1;
    for (int c = 0; c < 7000 && n < 256; c++) begin
      tick();
      if (done) begin
        if (frame_cnt !== 8'(n + 1)) bad++;
        n++;
      end
    end
    start = 1'b0;
    checks++; if (n != 256) begin errors++; $display("FAIL t6_frames_timeout: got %0d frames, required 256", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL t6_cnt_step: got %0d bad steps, required 0", bad); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL t6_wrap: got %0d, required 0", frame_cnt); end
    wait_idle("t6", 60);
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL t6_pending_frame: got %0d, required 1", frame_cnt); end
    checks++; if (max_raddr != 17) begin errors++; $display("FAIL t6_max_raddr: got %0d, required 17", max_raddr); end
    sb_en = 1'b1;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0100 + 16'(i);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_extra_starts();
    test_reset_mid_frame();
    test_sync_in_payload();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
